// File: rtl/dircc_types_pkg.sv
// Shared types for the dircc packet router.
// router_beat_t documents the FIFO entry layout {data, empty, sop, eop} for
// the default 32-bit / 4-symbol configuration; the router packs its entries
// in the same field order for any parameterisation.
package dircc_types_pkg;

  localparam int ROUTER_DATA_WIDTH  = 32;
  localparam int ROUTER_EMPTY_WIDTH = 2;

  typedef enum logic {
    ROUTE_LOCAL = 1'b0,
    ROUTE_NET   = 1'b1
  } router_dest_e;

  typedef struct packed {
    logic [ROUTER_DATA_WIDTH-1:0]  data;
    logic [ROUTER_EMPTY_WIDTH-1:0] empty;
    logic                          sop;
    logic                          eop;
  } router_beat_t;

endpackage

// File: rtl/dircc_beat_fifo.sv
// Synchronous beat FIFO with registered full/empty flags.
// Flags are computed from the next-state count, so a write in the same cycle
// as a read never overflows and full/empty are glitch-free registers.
// Writes while full and reads while empty are ignored.
module dircc_beat_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy from this cycle's accepted write/read.
  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and registered flags; pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dircc_packet_router.sv
// dircc_packet_router: buffers the PE's outgoing Avalon-ST beats and sends
// each whole packet to the local loopback port or the network port, chosen by
// comparing the first beat's low ADDRESS_MEM_WIDTH bits with `address`.
// Optional build macro DIRCC_ROUTER_STATS_EN adds saturating per-port
// packet counters (local_pkt_count, net_pkt_count).
//
// Handshake: a beat transfers on a port in any cycle where valid && ready.
// While forwarding, valid is held and payload is stable until ready; the
// non-selected port's valid is always 0.
module dircc_packet_router
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL   = 8,
  parameter int SYMBOLS_PER_BEAT  = 4,
  parameter int FIFO_DEPTH        = 8,
  parameter int ADDRESS_MEM_WIDTH = 32,
  localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [EMPTY_WIDTH-1:0]       in_empty,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        local_data,
  output logic [EMPTY_WIDTH-1:0]       local_empty,
  output logic                         local_startofpacket,
  output logic                         local_endofpacket,
  output logic                         local_valid,
  input  logic                         local_ready,
  output logic [DATA_WIDTH-1:0]        net_data,
  output logic [EMPTY_WIDTH-1:0]       net_empty,
  output logic                         net_startofpacket,
  output logic                         net_endofpacket,
  output logic                         net_valid,
  input  logic                         net_ready,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  output logic                         err_orphan,
  output logic                         err_framing
`ifdef DIRCC_ROUTER_STATS_EN
  ,
  output logic [15:0]                  local_pkt_count,
  output logic [15:0]                  net_pkt_count
`endif
);

  localparam int ENTRY_W = DATA_WIDTH + EMPTY_WIDTH + 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  router_dest_e route_q, route_d;
  logic         first_q, first_d;
  logic         ready_en_q;
  logic         err_orphan_q, err_framing_q;

  logic                   fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]     wr_entry, head;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [EMPTY_WIDTH-1:0] head_empty;
  logic                   head_sop, head_eop;
  logic                   pop, sel_valid, sel_ready;
  logic                   set_orphan, set_framing;

  // Entry layout matches router_beat_t: {data, empty, sop, eop}.
  assign wr_entry   = {in_data, in_empty, in_startofpacket, in_endofpacket};
  assign head_data  = head[ENTRY_W-1 -: DATA_WIDTH];
  assign head_empty = head[2 +: EMPTY_WIDTH];
  assign head_sop   = head[1];
  assign head_eop   = head[0];

  // ready_en holds in_ready low through reset and the first clock after it.
  assign in_ready = ready_en_q && !fifo_full;

  dircc_beat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (in_valid && in_ready),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sel_ready = (route_q == ROUTE_LOCAL) ? local_ready : net_ready;

  // Both ports see the FIFO head; only the routed port gets valid.
  assign local_data          = head_data;
  assign local_empty         = head_empty;
  assign local_startofpacket = head_sop;
  assign local_endofpacket   = head_eop;
  assign local_valid         = sel_valid && (route_q == ROUTE_LOCAL);
  assign net_data            = head_data;
  assign net_empty           = head_empty;
  assign net_startofpacket   = head_sop;
  assign net_endofpacket     = head_eop;
  assign net_valid           = sel_valid && (route_q == ROUTE_NET);

  assign err_orphan  = err_orphan_q;
  assign err_framing = err_framing_q;

  // FSM state, route latch, first-beat flag and sticky errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      route_q       <= ROUTE_LOCAL;
      first_q       <= 1'b0;
      ready_en_q    <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_framing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      first_q    <= first_d;
      ready_en_q <= 1'b1;
      if (set_orphan)  err_orphan_q  <= 1'b1;
      if (set_framing) err_framing_q <= 1'b1;
    end
  end

  // Next state: route on sop in IDLE, forward beats until the eop pop.
  // A sop arriving as a non-first beat ends the packet unpopped so IDLE
  // routes it afresh.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    first_d     = first_q;
    pop         = 1'b0;
    sel_valid   = 1'b0;
    set_orphan  = 1'b0;
    set_framing = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_sop) begin
            route_d = (head_data[ADDRESS_MEM_WIDTH-1:0] == address) ? ROUTE_LOCAL : ROUTE_NET;
            first_d = 1'b1;
            state_d = ST_FWD;
          end else begin
            pop        = 1'b1;
            set_orphan = 1'b1;
          end
        end
      end
      ST_FWD: begin
        if (!fifo_empty) begin
          if (head_sop && !first_q) begin
            set_framing = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            sel_valid = 1'b1;
            if (sel_ready) begin
              pop     = 1'b1;
              first_d = 1'b0;
              if (head_eop) state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DIRCC_ROUTER_STATS_EN
  logic [15:0] local_cnt_q, net_cnt_q;

  assign local_pkt_count = local_cnt_q;
  assign net_pkt_count   = net_cnt_q;

  // Saturating packet counters, stepped on each port's eop handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      local_cnt_q <= '0;
      net_cnt_q   <= '0;
    end else begin
      if (local_valid && local_ready && head_eop && local_cnt_q != 16'hFFFF)
        local_cnt_q <= local_cnt_q + 16'd1;
      if (net_valid && net_ready && head_eop && net_cnt_q != 16'hFFFF)
        net_cnt_q <= net_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dircc_packet_router.sv
// Directed bench for dircc_packet_router (address = 0x5).
// Build with +define+DIRCC_ROUTER_STATS_EN to include the counter scenario.
module tb_dircc_packet_router;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_empty = '0;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] local_data, net_data;
  logic [1:0]  local_empty, net_empty;
  logic        local_startofpacket, local_endofpacket, local_valid;
  logic        net_startofpacket, net_endofpacket, net_valid;
  logic        local_ready = 1'b1;
  logic        net_ready = 1'b1;
  logic [31:0] address = 32'h5;
  logic        err_orphan, err_framing;
`ifdef DIRCC_ROUTER_STATS_EN
  logic [15:0] local_pkt_count, net_pkt_count;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
    int          cyc;
  } obs_t;

  obs_t        local_q[$];
  obs_t        net_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  dircc_packet_router dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_data             (in_data),
    .in_empty            (in_empty),
    .in_startofpacket    (in_startofpacket),
    .in_endofpacket      (in_endofpacket),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .local_data          (local_data),
    .local_empty         (local_empty),
    .local_startofpacket (local_startofpacket),
    .local_endofpacket   (local_endofpacket),
    .local_valid         (local_valid),
    .local_ready         (local_ready),
    .net_data            (net_data),
    .net_empty           (net_empty),
    .net_startofpacket   (net_startofpacket),
    .net_endofpacket     (net_endofpacket),
    .net_valid           (net_valid),
    .net_ready           (net_ready),
    .address             (address),
    .err_orphan          (err_orphan),
    .err_framing         (err_framing)
`ifdef DIRCC_ROUTER_STATS_EN
    ,
    .local_pkt_count     (local_pkt_count),
    .net_pkt_count       (net_pkt_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every handshake with its cycle stamp.
  always @(negedge clk) begin
    obs_t o;
    if (local_valid && local_ready) begin
      o.data = local_data; o.empty = local_empty;
      o.sop = local_startofpacket; o.eop = local_endofpacket; o.cyc = cyc;
      local_q.push_back(o);
    end
    if (net_valid && net_ready) begin
      o.data = net_data; o.empty = net_empty;
      o.sop = net_startofpacket; o.eop = net_endofpacket; o.cyc = cyc;
      net_q.push_back(o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offers one beat and returns #1 after the edge that accepted it.
  task automatic drive_beat(input logic [31:0] d, input logic sop, input logic eop,
                            input logic [1:0] e);
    int budget;
    budget = 0;
    in_data = d; in_startofpacket = sop; in_endofpacket = eop; in_empty = e;
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      step(1);
      budget++;
    end
    if (!in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL drive_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    step(1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
  endtask

  task automatic clear_obs();
    local_q.delete(); net_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    tests_run++; if (local_valid !== 1'b0 || net_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valids: got %0b/%0b want 0/0", local_valid, net_valid); end
    tests_run++; if (err_orphan !== 1'b0 || err_framing !== 1'b0) begin tests_failed++; $display("FAIL rst_errs: got %0b/%0b want 0/0", err_orphan, err_framing); end
    step(2);
    reset_n = 1'b1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_rel_in_ready: got %0b want 0", in_ready); end
    step(1);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_first_clk_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_local_packet();
    int c0;
    clear_obs();
    c0 = cyc;
    drive_beat(32'h5, 1'b1, 1'b0, 2'd0);
    drive_beat(32'h1111_1111, 1'b0, 1'b0, 2'd0);
    drive_beat(32'h2222_2222, 1'b0, 1'b1, 2'd1);
    idle_in();
    step(6);
    tests_run++;
    if (local_q.size() != 3) begin
      tests_failed++; $display("FAIL local_count: got %0d beats want 3", local_q.size());
    end else begin
      tests_run++; if (local_q[0].cyc != c0 + 2 || local_q[0].data !== 32'h5 || local_q[0].sop !== 1'b1) begin tests_failed++; $display("FAIL local_beat0: cyc %0d data %0h sop %0b want cyc %0d data 5 sop 1", local_q[0].cyc, local_q[0].data, local_q[0].sop, c0 + 2); end
      tests_run++; if (local_q[1].cyc != c0 + 3 || local_q[1].data !== 32'h1111_1111 || local_q[1].sop !== 1'b0) begin tests_failed++; $display("FAIL local_beat1: cyc %0d data %0h want cyc %0d data 11111111", local_q[1].cyc, local_q[1].data, c0 + 3); end
      tests_run++; if (local_q[2].cyc != c0 + 4 || local_q[2].data !== 32'h2222_2222 || local_q[2].eop !== 1'b1 || local_q[2].empty !== 2'd1) begin tests_failed++; $display("FAIL local_beat2: cyc %0d data %0h eop %0b empty %0d want cyc %0d data 22222222 eop 1 empty 1", local_q[2].cyc, local_q[2].data, local_q[2].eop, local_q[2].empty, c0 + 4); end
    end
    tests_run++; if (net_q.size() != 0) begin tests_failed++; $display("FAIL local_no_net: got %0d net beats want 0", net_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c0;
    clear_obs();
    c0 = cyc;
    drive_beat(32'h9, 1'b1, 1'b0, 2'd0);
    drive_beat(32'hAA, 1'b0, 1'b1, 2'd0);
    drive_beat(32'h5, 1'b1, 1'b1, 2'd2);
    idle_in();
    step(8);
    tests_run++;
    if (net_q.size() != 2) begin
      tests_failed++; $display("FAIL b2b_net_count: got %0d want 2", net_q.size());
    end else begin
      tests_run++; if (net_q[0].cyc != c0 + 2 || net_q[0].data !== 32'h9 || net_q[0].sop !== 1'b1) begin tests_failed++; $display("FAIL b2b_net0: cyc %0d data %0h want cyc %0d data 9", net_q[0].cyc, net_q[0].data, c0 + 2); end
      tests_run++; if (net_q[1].cyc != c0 + 3 || net_q[1].data !== 32'hAA || net_q[1].eop !== 1'b1) begin tests_failed++; $display("FAIL b2b_net1: cyc %0d data %0h want cyc %0d data aa", net_q[1].cyc, net_q[1].data, c0 + 3); end
    end
    tests_run++;
    if (local_q.size() != 1) begin
      tests_failed++; $display("FAIL b2b_local_count: got %0d want 1", local_q.size());
    end else begin
      tests_run++; if (local_q[0].cyc != c0 + 5 || local_q[0].data !== 32'h5 || local_q[0].sop !== 1'b1 || local_q[0].eop !== 1'b1) begin tests_failed++; $display("FAIL b2b_local0: cyc %0d data %0h want cyc %0d data 5 sop/eop", local_q[0].cyc, local_q[0].data, c0 + 5); end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int budget;
    logic [31:0] d;
    logic        rdy;
    clear_obs();
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back((i == 0) ? 32'h9 : 32'h100 + i);
    net_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      d = exp_q[idx];
      in_data = d; in_startofpacket = (idx == 0); in_endofpacket = (idx == 9);
      in_empty = 2'd0; in_valid = 1'b1;
      rdy = in_ready;
      step(1);
      if (rdy) idx++;
    end
    tests_run++; if (idx != 8) begin tests_failed++; $display("FAIL bp_accepted: got %0d want 8", idx); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    tests_run++; if (net_valid !== 1'b1 || local_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valids: net %0b local %0b want 1/0", net_valid, local_valid); end
    net_ready = 1'b1;
    budget = 0;
    while (idx < 10 && budget < 40) begin
      d = exp_q[idx];
      in_data = d; in_startofpacket = (idx == 0); in_endofpacket = (idx == 9);
      in_valid = 1'b1;
      rdy = in_ready;
      step(1);
      if (rdy) idx++;
      budget++;
    end
    idle_in();
    step(16);
    tests_run++;
    if (net_q.size() != 10) begin
      tests_failed++; $display("FAIL bp_delivered: got %0d beats want 10", net_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (net_q[i].data !== exp_q[i]) begin tests_failed++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, net_q[i].data, exp_q[i]); end
      end
    end
    tests_run++; if (local_q.size() != 0) begin tests_failed++; $display("FAIL bp_no_local: got %0d want 0", local_q.size()); end
  endtask

  task automatic test_orphan();
    clear_obs();
    drive_beat(32'h5, 1'b0, 1'b1, 2'd0);
    idle_in();
    step(4);
    tests_run++; if (err_orphan !== 1'b1) begin tests_failed++; $display("FAIL orphan_flag: got %0b want 1", err_orphan); end
    tests_run++; if (local_q.size() != 0 || net_q.size() != 0) begin tests_failed++; $display("FAIL orphan_dropped: got %0d/%0d beats want 0/0", local_q.size(), net_q.size()); end
    drive_beat(32'h5, 1'b1, 1'b1, 2'd0);
    idle_in();
    step(6);
    tests_run++; if (local_q.size() != 1 || net_q.size() != 0) begin tests_failed++; $display("FAIL orphan_next_pkt: got %0d/%0d beats want 1/0", local_q.size(), net_q.size()); end
    tests_run++; if (err_orphan !== 1'b1 || err_framing !== 1'b0) begin tests_failed++; $display("FAIL orphan_sticky: got %0b/%0b want 1/0", err_orphan, err_framing); end
  endtask

  task automatic test_framing_and_reset();
    clear_obs();
    drive_beat(32'h9, 1'b1, 1'b0, 2'd0);
    drive_beat(32'h33, 1'b0, 1'b0, 2'd0);
    drive_beat(32'h5, 1'b1, 1'b1, 2'd0);
    idle_in();
    step(8);
    tests_run++; if (err_framing !== 1'b1) begin tests_failed++; $display("FAIL framing_flag: got %0b want 1", err_framing); end
    tests_run++; if (net_q.size() != 2) begin tests_failed++; $display("FAIL framing_net_beats: got %0d want 2", net_q.size()); end
    tests_run++;
    if (local_q.size() != 1) begin
      tests_failed++; $display("FAIL framing_reroute: got %0d local beats want 1", local_q.size());
    end else if (local_q[0].data !== 32'h5 || local_q[0].sop !== 1'b1) begin
      tests_failed++; $display("FAIL framing_reroute: got data %0h sop %0b want 5/1", local_q[0].data, local_q[0].sop);
    end
    // Park a partial packet on the network port, then reset mid-packet.
    net_ready = 1'b0;
    drive_beat(32'h9, 1'b1, 1'b0, 2'd0);
    drive_beat(32'h44, 1'b0, 1'b0, 2'd0);
    idle_in();
    step(3);
    tests_run++; if (net_valid !== 1'b1) begin tests_failed++; $display("FAIL prerst_net_valid: got %0b want 1", net_valid); end
    clear_obs();
    reset_n = 1'b0;
    #1;
    tests_run++; if (net_valid !== 1'b0 || local_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valids: got %0b/%0b want 0/0", net_valid, local_valid); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %0b want 0", in_ready); end
    tests_run++; if (err_orphan !== 1'b0 || err_framing !== 1'b0) begin tests_failed++; $display("FAIL midrst_errs: got %0b/%0b want 0/0", err_orphan, err_framing); end
    step(1);
    reset_n = 1'b1;
    net_ready = 1'b1;
    step(5);
    tests_run++; if (net_q.size() != 0 || local_q.size() != 0) begin tests_failed++; $display("FAIL postrst_fifo_empty: got %0d/%0d beats want 0/0", net_q.size(), local_q.size()); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL postrst_in_ready: got %0b want 1", in_ready); end
    drive_beat(32'h9, 1'b1, 1'b1, 2'd0);
    idle_in();
    step(5);
    tests_run++; if (net_q.size() != 1 || local_q.size() != 0) begin tests_failed++; $display("FAIL postrst_pkt: got %0d/%0d beats want 1/0", net_q.size(), local_q.size()); end
  endtask

`ifdef DIRCC_ROUTER_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'h5, 1'b1, 1'b0, 2'd0);
      drive_beat(32'h77, 1'b0, 1'b1, 2'd0);
    end
    for (int i = 0; i < 2; i++) drive_beat(32'h9, 1'b1, 1'b1, 2'd0);
    idle_in();
    step(20);
    tests_run++; if (local_pkt_count !== 16'd4) begin tests_failed++; $display("FAIL stats_local: got %0d want 4", local_pkt_count); end
    tests_run++; if (net_pkt_count !== 16'd2) begin tests_failed++; $display("FAIL stats_net: got %0d want 2", net_pkt_count); end
    force dut.local_cnt_q = 16'hFFFF;
    step(1);
    release dut.local_cnt_q;
    drive_beat(32'h5, 1'b1, 1'b1, 2'd0);
    idle_in();
    step(6);
    tests_run++; if (local_pkt_count !== 16'hFFFF) begin tests_failed++; $display("FAIL stats_saturate: got %0h want ffff", local_pkt_count); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_local_packet();
    test_back_to_back();
    test_backpressure();
    test_orphan();
    test_framing_and_reset();
`ifdef DIRCC_ROUTER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
